// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types, widths and sizing helpers for the UART command framer
package uart_cmd_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE,
    COLLECT
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_BUSY
  } tx_state_t;

  // bits needed to hold the value n itself (counters that reach n)
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  // bits needed to index n entries
  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_cmd_framer_if.sv
// rtl/uart_cmd_framer_if.sv - UART, command and response signals of the framer
interface uart_cmd_framer_if #(
  parameter int CMD_BYTES = 2
);
  import uart_cmd_pkg::*;

  logic                        rx_rdy;
  logic [BYTE_W-1:0]           rx_data;
  logic                        clr_rx_rdy;
  logic [BYTE_W*CMD_BYTES-1:0] cmd;
  logic                        cmd_rdy;
  logic                        clr_cmd_rdy;
  logic                        cmd_ovr;
  logic                        frame_err;
  logic                        resp_wr;
  logic [BYTE_W-1:0]           resp;
  logic                        resp_full;
  logic                        tx_trmt;
  logic [BYTE_W-1:0]           tx_data;
  logic                        tx_done;

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, resp_wr, resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, frame_err, resp_full, tx_trmt, tx_data
  );

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, resp_wr, resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, frame_err, resp_full, tx_trmt, tx_data
  );

endinterface

// File: rtl/resp_fifo.sv
// rtl/resp_fifo.sv - power-of-two response byte FIFO, writes to a full FIFO are dropped
module resp_fifo
  import uart_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  // full is judged before any same-cycle pop, so a pop never rescues a write
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/uart_cmd_framer.sv
// rtl/uart_cmd_framer.sv - assembles UART bytes into commands and serialises queued responses
module uart_cmd_framer
  import uart_cmd_pkg::*;
#(
  parameter int CMD_BYTES   = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int RESP_DEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  uart_cmd_framer_if.slave bus
);
  localparam int CMD_W = BYTE_W * CMD_BYTES;
  localparam int BCW   = cnt_w(CMD_BYTES);
  localparam int TW    = cnt_w(TIMEOUT_CYC);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(CMD_BYTES - 1);
  localparam logic [TW-1:0]  T_LAST   = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  rx_state_t        rx_state;
  logic [BCW-1:0]   byte_cnt;
  logic [TW-1:0]    timer;
  logic [CMD_W-1:0] shift_q;
  logic [CMD_W-1:0] shift_next;
  logic             complete;
  logic             overrun;
  logic             timed_out;

  tx_state_t        tx_state;
  logic             busy_first;
  logic             fifo_pop;
  logic             fifo_empty;
  logic [BYTE_W-1:0] fifo_dout;

  assign bus.clr_rx_rdy = bus.rx_rdy;
  // oldest bytes fall off the top, so stale bits never survive a full frame
  assign shift_next = CMD_W'({shift_q, bus.rx_data});
  assign complete   = bus.rx_rdy && ((rx_state == IDLE && CMD_BYTES == 1) ||
                                     (rx_state == COLLECT && byte_cnt == LAST_IDX));
  assign overrun    = complete && bus.cmd_rdy && !bus.clr_cmd_rdy;
  assign timed_out  = (TIMEOUT_CYC != 0) && (rx_state == COLLECT) && !bus.rx_rdy &&
                      (timer == T_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state      <= IDLE;
      byte_cnt      <= '0;
      timer         <= '0;
      shift_q       <= '0;
      bus.cmd       <= '0;
      bus.cmd_rdy   <= 1'b0;
      bus.cmd_ovr   <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= timed_out;
      if (complete) begin
        rx_state <= IDLE;
        byte_cnt <= '0;
        timer    <= '0;
        bus.cmd  <= shift_next;
      end else if (bus.rx_rdy) begin
        rx_state <= COLLECT;
        byte_cnt <= byte_cnt + 1'b1;
        timer    <= '0;
        shift_q  <= shift_next;
      end else if (timed_out) begin
        rx_state <= IDLE;
        byte_cnt <= '0;
        timer    <= '0;
      end else if (rx_state == COLLECT && TIMEOUT_CYC != 0) begin
        timer <= timer + 1'b1;
      end

      if (complete) bus.cmd_rdy <= 1'b1;
      else if (bus.clr_cmd_rdy) bus.cmd_rdy <= 1'b0;

      if (overrun) bus.cmd_ovr <= 1'b1;
      else if (bus.clr_cmd_rdy) bus.cmd_ovr <= 1'b0;
    end
  end

  assign fifo_pop = (tx_state == TX_IDLE) && !fifo_empty;

  resp_fifo #(
    .DEPTH(RESP_DEPTH),
    .WIDTH(BYTE_W)
  ) u_resp_fifo (
    .clk  (clk),
    .rst  (rst),
    .wr   (bus.resp_wr),
    .din  (bus.resp),
    .rd   (fifo_pop),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (bus.resp_full)
  );

  // the UART cannot raise tx_done in the cycle right after the strobe, so that cycle is skipped
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state    <= TX_IDLE;
      busy_first  <= 1'b0;
      bus.tx_trmt <= 1'b0;
      bus.tx_data <= '0;
    end else begin
      bus.tx_trmt <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            bus.tx_data <= fifo_dout;
            bus.tx_trmt <= 1'b1;
            tx_state    <= TX_START;
          end
        end
        TX_START: begin
          busy_first <= 1'b1;
          tx_state   <= TX_BUSY;
        end
        TX_BUSY: begin
          if (busy_first) busy_first <= 1'b0;
          else if (bus.tx_done) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb/tb_uart_cmd_framer.sv - bench for uart_cmd_framer against a queue-based reference model
module tb_uart_cmd_framer;
  import uart_cmd_pkg::*;

  localparam int A_BYTES = 2;
  localparam int A_TMO   = 20;
  localparam int A_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_cmd_framer_if #(.CMD_BYTES(A_BYTES)) bus_a ();
  uart_cmd_framer_if #(.CMD_BYTES(3))       bus_b ();
  uart_cmd_framer_if #(.CMD_BYTES(1))       bus_c ();

  uart_cmd_framer #(.CMD_BYTES(A_BYTES), .TIMEOUT_CYC(A_TMO), .RESP_DEPTH(A_DEPTH))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  uart_cmd_framer #(.CMD_BYTES(3), .TIMEOUT_CYC(20), .RESP_DEPTH(4))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  uart_cmd_framer #(.CMD_BYTES(1), .TIMEOUT_CYC(0), .RESP_DEPTH(2))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: bytes of the open frame, delivered command, response queue, transmitter age
  logic [7:0]           frame_q[$];
  int                   idle_cnt;
  logic [8*A_BYTES-1:0] m_cmd;
  bit                   m_rdy, m_ovr, m_ferr;
  logic [7:0]           fifo_q[$];
  int                   tx_age;
  logic [7:0]           m_txd;
  bit                   rst_req;
  logic [7:0]           tx_seen[$];

  task automatic model_reset();
    frame_q.delete();
    fifo_q.delete();
    idle_cnt = 0;
    m_cmd = '0;
    m_rdy = 0;
    m_ovr = 0;
    m_ferr = 0;
    tx_age = 0;
    m_txd = '0;
  endtask

  task automatic model_a(input bit rr, input logic [7:0] rd, input bit cl, input bit wr,
                         input logic [7:0] rs, input bit dn);
    bit completed, over, pop, push;
    logic [8*A_BYTES-1:0] w;
    if (rst_req) begin
      model_reset();
      return;
    end
    completed = 0;
    m_ferr = 0;
    if (rr) begin
      frame_q.push_back(rd);
      idle_cnt = 0;
      if (frame_q.size() == A_BYTES) begin
        w = '0;
        foreach (frame_q[i]) w = (w << 8) | (8*A_BYTES)'(frame_q[i]);
        m_cmd = w;
        completed = 1;
        frame_q.delete();
      end
    end else if (frame_q.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == A_TMO) begin
        frame_q.delete();
        idle_cnt = 0;
        m_ferr = 1;
      end
    end
    over = completed && m_rdy && !cl;
    if (completed) m_rdy = 1;
    else if (cl) m_rdy = 0;
    if (over) m_ovr = 1;
    else if (cl) m_ovr = 0;

    // age 1 = strobe cycle, age 2 = tx_done ignored, age >= 3 = waiting for tx_done
    pop  = (tx_age == 0) && (fifo_q.size() > 0);
    push = wr && (fifo_q.size() < A_DEPTH);
    if (pop) begin
      m_txd = fifo_q.pop_front();
      tx_age = 1;
    end else if (tx_age >= 3 && dn) tx_age = 0;
    else if (tx_age > 0 && tx_age < 3) tx_age++;
    if (push) fifo_q.push_back(rs);
  endtask

  task automatic step_a(input bit rr, input logic [7:0] rd, input bit cl, input bit wr,
                        input logic [7:0] rs, input bit dn);
    @(negedge clk);
    check("a_cmd", 64'(bus_a.cmd), 64'(m_cmd));
    check("a_cmd_rdy", 64'(bus_a.cmd_rdy), 64'(m_rdy));
    check("a_cmd_ovr", 64'(bus_a.cmd_ovr), 64'(m_ovr));
    check("a_frame_err", 64'(bus_a.frame_err), 64'(m_ferr));
    check("a_resp_full", 64'(bus_a.resp_full), 64'(fifo_q.size() == A_DEPTH));
    check("a_tx_trmt", 64'(bus_a.tx_trmt), 64'(tx_age == 1));
    check("a_tx_data", 64'(bus_a.tx_data), 64'(m_txd));
    if (bus_a.tx_trmt) tx_seen.push_back(bus_a.tx_data);
    rst               = rst_req;
    bus_a.rx_rdy      = rr;
    bus_a.rx_data     = rd;
    bus_a.clr_cmd_rdy = cl;
    bus_a.resp_wr     = wr;
    bus_a.resp        = rs;
    bus_a.tx_done     = dn;
    #1;
    check("a_clr_rx_rdy", 64'(bus_a.clr_rx_rdy), 64'(rr));
    model_a(rr, rd, cl, wr, rs, dn);
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) step_a(0, 8'h00, 0, 0, 8'h00, 0);
  endtask

  task automatic byte_a(input logic [7:0] b, input bit cl);
    step_a(1, b, cl, 0, 8'h00, 0);
  endtask

  task automatic send_b(input logic [7:0] b);
    @(negedge clk);
    bus_b.rx_rdy  = 1'b1;
    bus_b.rx_data = b;
    #1;
    check("b_clr_rx_rdy", 64'(bus_b.clr_rx_rdy), 64'(1));
    @(negedge clk);
    bus_b.rx_rdy = 1'b0;
  endtask

  initial begin
    int silence, first_k, pulses;
    logic [7:0] exp_tx[5];

    rst = 1'b1;
    bus_a.rx_rdy = 0; bus_a.rx_data = 0; bus_a.clr_cmd_rdy = 0;
    bus_a.resp_wr = 0; bus_a.resp = 0; bus_a.tx_done = 0;
    bus_b.rx_rdy = 0; bus_b.rx_data = 0; bus_b.clr_cmd_rdy = 0;
    bus_b.resp_wr = 0; bus_b.resp = 0; bus_b.tx_done = 0;
    bus_c.rx_rdy = 0; bus_c.rx_data = 0; bus_c.clr_cmd_rdy = 0;
    bus_c.resp_wr = 0; bus_c.resp = 0; bus_c.tx_done = 0;
    rst_req = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    idle_a(2);

    // two-byte command, then consumer acknowledge
    byte_a(8'hA5, 0);
    byte_a(8'h3C, 0);
    idle_a(1);
    check("t1_cmd", 64'(bus_a.cmd), 64'h A53C);
    check("t1_cmd_rdy", 64'(bus_a.cmd_rdy), 64'(1));
    step_a(0, 8'h00, 1, 0, 8'h00, 0);
    idle_a(1);
    check("t1_cleared", 64'(bus_a.cmd_rdy), 64'(0));
    check("t1_cmd_held", 64'(bus_a.cmd), 64'h A53C);

    // overrun, its clearing, and clear coinciding with completion
    byte_a(8'h12, 0); byte_a(8'h34, 0);
    byte_a(8'h56, 0); byte_a(8'h78, 0);
    idle_a(1);
    check("ovr_cmd", 64'(bus_a.cmd), 64'h5678);
    check("ovr_flag", 64'(bus_a.cmd_ovr), 64'(1));
    step_a(0, 8'h00, 1, 0, 8'h00, 0);
    idle_a(1);
    check("ovr_clr_rdy", 64'(bus_a.cmd_rdy), 64'(0));
    check("ovr_clr_flag", 64'(bus_a.cmd_ovr), 64'(0));
    byte_a(8'h9A, 0); byte_a(8'hBC, 0);
    byte_a(8'hDE, 0); byte_a(8'hF0, 1);
    idle_a(1);
    check("coinc_rdy", 64'(bus_a.cmd_rdy), 64'(1));
    check("coinc_ovr", 64'(bus_a.cmd_ovr), 64'(0));
    check("coinc_cmd", 64'(bus_a.cmd), 64'hDEF0);

    // response FIFO fills behind a busy transmitter, fifth push is dropped
    tx_seen.delete();
    step_a(0, 8'h00, 0, 1, 8'hEE, 0);
    idle_a(2);
    for (int i = 0; i < 5; i++) step_a(0, 8'h00, 0, 1, 8'(8'h10 + i), 0);
    idle_a(1);
    check("fifo_full", 64'(bus_a.resp_full), 64'(1));
    for (int i = 0; i < 60; i++) step_a(0, 8'h00, 0, 0, 8'h00, 1);
    exp_tx = '{8'hEE, 8'h10, 8'h11, 8'h12, 8'h13};
    check("tx_count", 64'(tx_seen.size()), 64'(5));
    for (int i = 0; i < 5; i++)
      if (i < tx_seen.size()) check("tx_order", 64'(tx_seen[i]), 64'(exp_tx[i]));
    check("fifo_drained", 64'(bus_a.resp_full), 64'(0));

    // reset mid-frame and mid-transmission
    step_a(0, 8'h00, 0, 1, 8'h55, 0);
    idle_a(4);
    byte_a(8'hAB, 0);
    rst_req = 1'b1;
    idle_a(1);
    rst_req = 1'b0;
    idle_a(1);
    check("rst_cmd", 64'(bus_a.cmd), 64'(0));
    check("rst_cmd_rdy", 64'(bus_a.cmd_rdy), 64'(0));
    check("rst_tx_data", 64'(bus_a.tx_data), 64'(0));
    check("rst_tx_trmt", 64'(bus_a.tx_trmt), 64'(0));
    byte_a(8'hBE, 0); byte_a(8'hEF, 0);
    idle_a(1);
    check("rst_fresh_cmd", 64'(bus_a.cmd), 64'hBEEF);

    // randomized traffic against the model, with silences straddling the timeout
    silence = 0;
    for (int i = 0; i < 2000; i++) begin
      bit rr;
      if (silence > 0) begin
        silence--;
        rr = 0;
      end else if ($urandom_range(0, 39) == 0) begin
        silence = $urandom_range(15, 25);
        rr = 0;
      end else begin
        rr = ($urandom_range(0, 2) == 0);
      end
      rst_req = ($urandom_range(0, 399) == 0);
      step_a(rr, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             8'($urandom), $urandom_range(0, 3) == 0);
    end
    rst_req = 1'b0;
    idle_a(2);

    // three-byte commands with a 20-cycle inter-byte timeout
    send_b(8'h11);
    first_k = 0;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      if (bus_b.frame_err) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
      @(negedge clk);
    end
    check("b_ferr_cycle", 64'(first_k), 64'(21));
    check("b_ferr_pulses", 64'(pulses), 64'(1));
    check("b_cmd_kept", 64'(bus_b.cmd), 64'(0));
    check("b_rdy_kept", 64'(bus_b.cmd_rdy), 64'(0));
    send_b(8'h01); send_b(8'h02); send_b(8'h03);
    check("b_cmd", 64'(bus_b.cmd), 64'h010203);
    check("b_cmd_rdy", 64'(bus_b.cmd_rdy), 64'(1));

    // single-byte commands, timeout disabled, back-to-back bytes overrun
    pulses = 0;
    @(negedge clk);
    bus_c.rx_rdy  = 1'b1;
    bus_c.rx_data = 8'h7F;
    #1;
    check("c_clr_rx_rdy", 64'(bus_c.clr_rx_rdy), 64'(1));
    @(negedge clk);
    check("c_cmd_first", 64'(bus_c.cmd), 64'h7F);
    check("c_ovr_first", 64'(bus_c.cmd_ovr), 64'(0));
    bus_c.rx_data = 8'h80;
    @(negedge clk);
    bus_c.rx_rdy = 1'b0;
    check("c_cmd", 64'(bus_c.cmd), 64'h80);
    check("c_cmd_rdy", 64'(bus_c.cmd_rdy), 64'(1));
    check("c_cmd_ovr", 64'(bus_c.cmd_ovr), 64'(1));
    for (int k = 0; k < 30; k++) begin
      if (bus_c.frame_err) pulses++;
      @(negedge clk);
    end
    check("c_no_frame_err", 64'(pulses), 64'(0));
    bus_c.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus_c.clr_cmd_rdy = 1'b0;
    check("c_clr_rdy", 64'(bus_c.cmd_rdy), 64'(0));
    check("c_clr_ovr", 64'(bus_c.cmd_ovr), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
